// File: rtl/mux_2_1_if.sv
// mux_2_1_if: bundles the data/select inputs and the mux results of mux_2_1.
// Optional feature macro: MUX_2_1_STATS_EN adds the sw_cnt select-change counter.
// master = the side driving a/b/s, slave = the mux itself.

interface mux_2_1_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             s;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic             sel_q;
`ifdef MUX_2_1_STATS_EN
    logic [CNT_W-1:0] sw_cnt;
`endif

    // Both widths must be at least one bit for the data path and counter to exist.
    if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
        $error("mux_2_1_if: WIDTH and CNT_W must be at least 1");
    end

`ifdef MUX_2_1_STATS_EN
    modport master (
        output a,
        output b,
        output s,
        input  out,
        input  out_q,
        input  sel_q,
        input  sw_cnt
    );

    modport slave (
        input  a,
        input  b,
        input  s,
        output out,
        output out_q,
        output sel_q,
        output sw_cnt
    );
`else
    modport master (
        output a,
        output b,
        output s,
        input  out,
        input  out_q,
        input  sel_q
    );

    modport slave (
        input  a,
        input  b,
        input  s,
        output out,
        output out_q,
        output sel_q
    );
`endif

endinterface

// File: rtl/mux_2_1.sv
// mux_2_1: 2:1 multiplexer with a combinational result plus registered copies
// of the result and of the select.
// Optional feature macro: MUX_2_1_STATS_EN adds a saturating counter (sw_cnt)
// of select changes, measured against the registered select.

module mux_2_1 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input logic       clk,
    input logic       rst,
    mux_2_1_if.slave  bus
);

    logic [WIDTH-1:0] mux_val;
    logic [WIDTH-1:0] out_q_reg;
    logic             sel_q_reg;

    // Both widths must be at least one bit for the data path and counter to exist.
    if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
        $error("mux_2_1: WIDTH and CNT_W must be at least 1");
    end

    // Pure combinational select; independent of clk and rst so it works with the clock stopped.
    always_comb begin
        mux_val = bus.s ? bus.b : bus.a;
    end

    assign bus.out = mux_val;

    // Capture the mux result and the select one cycle later; reset clears them without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q_reg <= '0;
            sel_q_reg <= 1'b0;
        end else begin
            out_q_reg <= mux_val;
            sel_q_reg <= bus.s;
        end
    end

    assign bus.out_q = out_q_reg;
    assign bus.sel_q = sel_q_reg;

`ifdef MUX_2_1_STATS_EN
    logic [CNT_W-1:0] cnt_reg;

    // Count edges where the live select differs from the registered one, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if ((bus.s != sel_q_reg) && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign bus.sw_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_mux_2_1.sv
// tb_mux_2_1: scoreboard bench for mux_2_1. Stimulus pushes expected values into
// a queue and signals the monitor, which samples the DUT and compares.
// Builds with or without MUX_2_1_STATS_EN; the counter section only exists with it.

module tb_mux_2_1;

    localparam int WIDTH = 32;
`ifdef MUX_2_1_STATS_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif

    localparam int SIG_OUT    = 0;
    localparam int SIG_OUT_Q  = 1;
    localparam int SIG_SEL_Q  = 2;
    localparam int SIG_SW_CNT = 3;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] exp;
    } check_t;

    logic clk     = 1'b0;
    logic clk_run = 1'b0;
    logic rst     = 1'b1;

    check_t      exp_q [$];
    event        check_ev;
    int          passed_count = 0;
    int          total_count  = 0;
    check_t      entry;
    logic [31:0] got;

    logic [31:0] vec_a   [6] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000001, 32'hCAFEF00D};
    logic [31:0] vec_b   [6] = '{32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic        vec_s   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] vec_out [6] = '{32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'h00000001, 32'hFFFFFFFF};

    logic [31:0] prev_out;
    logic        prev_s;

    mux_2_1_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    mux_2_1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Gated 100 MHz clock: held low until the bench enables it.
    always #5 clk = clk_run ? ~clk : 1'b0;

    task automatic applyStimulus(input logic [31:0] a_val, input logic [31:0] b_val, input logic s_val);
        bus.a = a_val;
        bus.b = b_val;
        bus.s = s_val;
    endtask

    task automatic checkOutput(input string name, input int sig, input logic [31:0] exp);
        check_t c;
        c.name = name;
        c.sig  = sig;
        c.exp  = exp;
        exp_q.push_back(c);
    endtask

    task automatic flushChecks();
        -> check_ev;
        #1;
        if (exp_q.size() != 0) begin
            $display("[TB] FAIL monitor_stall: %0d checks pending, required 0", exp_q.size());
            total_count += exp_q.size();
            exp_q.delete();
        end
    endtask

    // Monitor: on each presentation event, sample the DUT and drain the scoreboard.
    always begin
        @(check_ev);
        while (exp_q.size() != 0) begin
            entry = exp_q.pop_front();
            got   = 32'h0;
            case (entry.sig)
                SIG_OUT:    got = bus.out;
                SIG_OUT_Q:  got = bus.out_q;
                SIG_SEL_Q:  got = {31'h0, bus.sel_q};
`ifdef MUX_2_1_STATS_EN
                SIG_SW_CNT: got = {{(32-CNT_W){1'b0}}, bus.sw_cnt};
`endif
                default:    got = 32'hXXXXXXXX;
            endcase
            total_count++;
            if (got === entry.exp) begin
                passed_count++;
            end else begin
                $display("[TB] FAIL %s: got %h, expected %h", entry.name, got, entry.exp);
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset held with no clock: registered outputs clear asynchronously.
        rst = 1'b1;
        applyStimulus(32'h0, 32'h0, 1'b0);
        #3;
        checkOutput("reset_out_q", SIG_OUT_Q, 32'h0);
        checkOutput("reset_sel_q", SIG_SEL_Q, 32'h0);
`ifdef MUX_2_1_STATS_EN
        checkOutput("reset_sw_cnt", SIG_SW_CNT, 32'h0);
`endif
        flushChecks();

        // Combinational path with the clock stopped.
        applyStimulus(32'h0, 32'd12, 1'b0);
        #1;
        checkOutput("noclk_s0_out", SIG_OUT, 32'h0);
        flushChecks();
        bus.s = 1'b1;
        #100;
        checkOutput("noclk_s1_out", SIG_OUT, 32'd12);
        flushChecks();
        applyStimulus(32'h5, 32'd12, 1'b0);
        #1;
        checkOutput("noclk_a_follow", SIG_OUT, 32'h5);
        flushChecks();

        // Release reset and start the clock; the first edge loads out=5, s=0.
        rst = 1'b0;
        clk_run = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("first_edge_out_q", SIG_OUT_Q, 32'h5);
        checkOutput("first_edge_sel_q", SIG_SEL_Q, 32'h0);
        flushChecks();
        prev_out = 32'h5;
        prev_s   = 1'b0;

        // Directed vectors: out is immediate, out_q/sel_q lag by exactly one edge.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vec_a[i], vec_b[i], vec_s[i]);
            #1;
            checkOutput($sformatf("vec%0d_out", i), SIG_OUT, vec_out[i]);
            checkOutput($sformatf("vec%0d_out_q_pre", i), SIG_OUT_Q, prev_out);
            checkOutput($sformatf("vec%0d_sel_q_pre", i), SIG_SEL_Q, {31'h0, prev_s});
            flushChecks();
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_out_q", i), SIG_OUT_Q, vec_out[i]);
            checkOutput($sformatf("vec%0d_sel_q", i), SIG_SEL_Q, {31'h0, vec_s[i]});
            flushChecks();
            prev_out = vec_out[i];
            prev_s   = vec_s[i];
        end

        // Mid-cycle reset: registered state clears at once, out is untouched.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_q", SIG_OUT_Q, 32'h0);
        checkOutput("midrst_sel_q", SIG_SEL_Q, 32'h0);
        checkOutput("midrst_out", SIG_OUT, 32'hFFFFFFFF);
        flushChecks();
        @(posedge clk);
        #1;
        checkOutput("rst_hold_out_q", SIG_OUT_Q, 32'h0);
        checkOutput("rst_hold_sel_q", SIG_SEL_Q, 32'h0);
        flushChecks();

        // Release reset with s=1; loading resumes on the next edge.
        applyStimulus(32'h00001234, 32'h80000001, 1'b1);
        rst = 1'b0;
        #1;
        checkOutput("release_out", SIG_OUT, 32'h80000001);
        flushChecks();
        @(posedge clk);
        #1;
        checkOutput("release_out_q", SIG_OUT_Q, 32'h80000001);
        checkOutput("release_sel_q", SIG_SEL_Q, 32'h1);
        flushChecks();

`ifdef MUX_2_1_STATS_EN
        // Counter saturation: s toggles every edge starting from reset sel_q=0.
        rst = 1'b1;
        applyStimulus(32'h0, 32'h0, 1'b0);
        #1;
        checkOutput("cnt_reset", SIG_SW_CNT, 32'h0);
        flushChecks();
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            bus.s = k[0];
            @(posedge clk);
            #1;
            checkOutput($sformatf("cnt_edge%0d", k), SIG_SW_CNT, (k < 15) ? k : 32'd15);
            flushChecks();
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("cnt_hold%0d", k), SIG_SW_CNT, 32'd15);
            flushChecks();
        end
`endif

        clk_run = 1'b0;
        #20;
        $display("[TB] %0d/%0d checks passed", passed_count, total_count);
        $finish;
    end

endmodule
